dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the 32 × 20-bit data memory. It accepts single-word read/write requests from port A (CPU load/store stage) and port B (debug/DMA loader), and issues exactly one memory access at a time. It drives the memory's address, write-data, write, read and memtoreg controls, and returns read data to the winning requester. It sits between the requesters and the DataMemory instance; the requesters never drive the memory directly.

## Interface
Parameters:
- `AW`, 20: address width forwarded to memory; the memory decodes only bits [4:0].
- `DW`, 20: data width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `a_req`, `b_req` in 1: request; held high until the matching `gnt` is seen.
- `a_we`, `b_we` in 1: 1 = write, 0 = read; stable while `req` is high.
- `a_addr`, `b_addr` in AW: word address.
- `a_wdata`, `b_wdata` in DW: write data.
- `a_gnt`, `b_gnt` out 1: one-cycle pulse; the request is accepted and is being issued.
- `a_rvalid`, `b_rvalid` out 1: one-cycle pulse; read data is valid.
- `a_rdata`, `b_rdata` out DW: read data, meaningful only while `rvalid` is high. Otherwise 0.
- `mem_addr` out AW, `mem_wdata` out DW, `mem_write` out 1, `mem_read` out 1, `mem_toreg` out 1: drive the memory.
- `mem_rdata` in DW: memory `readData`, registered inside the memory with 1-cycle latency.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: `req` is sampled only here. Any request latches the winner, its `we`, `addr` and `wdata`, then moves to ISSUE.
  - ISSUE: exactly 1 cycle. The winner's `gnt` is high; `mem_addr`/`mem_wdata` come from the latch; `mem_write` = we; `mem_read` = !we. A write goes to IDLE; a read goes to RESP.
  - RESP: exactly 1 cycle. The winner's `rvalid` is high and its `rdata` = `mem_rdata` (combinational pass-through). Then go to IDLE.
- `mem_toreg` is 1 at all times out of reset. This prevents the memory's address-bypass path from overwriting `readData`.
- `mem_read` and `mem_write` are never high together and are never high outside ISSUE.
- Arbitration applies only when both requests are high in IDLE. A single request always wins.
- `req` seen in the RESP cycle or in the cycle after `gnt` is ignored until the state returns to IDLE. A requester that leaves `req` high after `gnt` is issuing a new request.
- Latched request registers are not cleared after completion; only the outputs are gated by state.

## Timing
- Reset values: state IDLE; all `gnt`, `rvalid`, `mem_write`, `mem_read` and `busy` are 0; `rdata` and `mem_*` data/address are 0; `mem_toreg` = 0 while `rst` is high, 1 after release; the last-grant register points to B.
- Request sampled at edge N means: `gnt` and the memory command occur in cycle N+1. A write commits at edge N+1.
- Read data is captured by the memory at edge N+1, and `rvalid` plus `rdata` appear in cycle N+2.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- `rst` asserted during ISSUE, before the edge, drops `mem_write` immediately, so no write commits. `rst` during RESP suppresses `rvalid`.
- When `rst` is released with `req` high, the request is sampled at the first following edge.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On a tie, the grant goes to the port not granted last. A 1-bit last-grant register updates at every IDLE→ISSUE transition; after reset A wins the first tie.
- Undefined: fixed priority, A always wins ties. The last-grant register is not instantiated. Continuous A requests may starve B, and this is accepted behaviour.

## Structure
- Package `dmem_arb_pkg` holds:
  - constants AW = 20 and DW = 20, and MEM_WORDS = 32;
  - the state enum (IDLE, ISSUE, RESP);
  - a port-select enum (PORT_A, PORT_B).
- Sub-module `dmem_arb_pick2`: combinational 2-way picker with inputs `req_a`, `req_b`, `last` and output `sel`. It contains the `DMEM_ARB_RR_EN` conditional, so the FSM stays policy-agnostic.

## Test plan
- A write addr 5, data 0x000AB, then an A read addr 5 → `a_gnt` 1 cycle after each sample, `mem_write` pulses once, `a_rvalid` with `a_rdata` = 0x000AB 2 cycles after the read sample.
- B read addr 7 after reset (memory initialised to index) → `b_rdata` = 0x00007, `mem_toreg` = 1, `mem_read` high for exactly 1 cycle.
- A and B both request reads every cycle for 8 grants:
  - with `DMEM_ARB_RR_EN`, grants alternate A,B,A,B…;
  - without it, all 8 grants go to A.
- A write addr 3 data 0xFFFFF with `rst` pulsed in the ISSUE cycle → no commit; a later read of addr 3 returns 0x00003; all outputs are 0 during reset.
- A read addr 0x00025 → `mem_addr` = 0x00025 forwarded; `rdata` = the content of word 5 (aliasing by bits [4:0]).
- `busy`, `gnt` and `rvalid` are never high outside ISSUE/RESP; `mem_read` & `mem_write` is never 1 in any cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared widths, memory depth, FSM state and port-select types for dmem_arbiter.
package dmem_arb_pkg;
   localparam int AW        = 20;
   localparam int DW        = 20;
   localparam int MEM_WORDS = 32;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester A/B handshakes plus data-memory command bus.
// Ports: a_*/b_* req, we, addr, wdata, gnt, rvalid, rdata; mem_* addr, wdata, write, read, toreg, rdata; busy.
// Modports: slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if #(
   parameter int AW = dmem_arb_pkg::AW,
   parameter int DW = dmem_arb_pkg::DW
);
   logic          a_req, a_we, a_gnt, a_rvalid;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata, a_rdata;
   logic          b_req, b_we, b_gnt, b_rvalid;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata, b_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_write, mem_read, mem_toreg, busy;
   modport slave (
      input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
      output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
             mem_addr, mem_wdata, mem_write, mem_read, mem_toreg, busy
   );
   modport master (
      output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
      input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
             mem_addr, mem_wdata, mem_write, mem_read, mem_toreg, busy
   );
endinterface

// File: rtl/dmem_arb_pick2.sv
// dmem_arb_pick2: combinational two-way picker; DMEM_ARB_RR_EN selects round-robin ties, else A wins ties.
// Ports: req_a, req_b (requests), last (port granted last), sel (winner; meaningful only with a request).
module dmem_arb_pick2
   import dmem_arb_pkg::*;
(
   input  logic  req_a,
   input  logic  req_b,
   input  port_t last,
   output port_t sel
);
`ifdef DMEM_ARB_RR_EN
   assign sel = (req_a && req_b) ? ((last == PORT_A) ? PORT_B : PORT_A)
                                 : (req_a ? PORT_A : PORT_B);
`else
   logic unused_last;
   assign unused_last = last;
   assign sel = (req_a || !req_b) ? PORT_A : PORT_B;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester sequencer issuing one 32x20 data-memory access at a time.
// Ports: clk, rst (async, active-high), bus (dmem_arbiter_if.slave: requester handshakes, memory command, busy).
// DMEM_ARB_RR_EN enables round-robin tie-break with a last-grant register; otherwise A has fixed priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = dmem_arb_pkg::AW,
   parameter int DW = dmem_arb_pkg::DW
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);
   state_t        state_q, state_d;
   port_t         sel_q, pick, last;
   logic          we_q, take, issue, resp;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   // requests are only looked at while idle
   assign take  = (state_q == IDLE) && (bus.a_req || bus.b_req);
   assign issue = state_q == ISSUE;
   assign resp  = state_q == RESP;
   dmem_arb_pick2 u_pick (.req_a(bus.a_req), .req_b(bus.b_req), .last(last), .sel(pick));
`ifdef DMEM_ARB_RR_EN
   port_t last_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) last_q <= PORT_B;
      else if (take) last_q <= pick;
   assign last = last_q;
`else
   assign last = PORT_B;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   always_comb
      state_d = (state_q == IDLE) ? (take ? ISSUE : IDLE) : ((issue && !we_q) ? RESP : IDLE);
   // the latched request is kept after completion; outputs below are gated by state instead
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sel_q   <= PORT_A;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (take) begin
         sel_q   <= pick;
         we_q    <= (pick == PORT_A) ? bus.a_we : bus.b_we;
         addr_q  <= (pick == PORT_A) ? bus.a_addr : bus.b_addr;
         wdata_q <= (pick == PORT_A) ? bus.a_wdata : bus.b_wdata;
      end
   always_comb begin
      bus.a_gnt     = issue && (sel_q == PORT_A);
      bus.b_gnt     = issue && (sel_q == PORT_B);
      bus.a_rvalid  = resp && (sel_q == PORT_A);
      bus.b_rvalid  = resp && (sel_q == PORT_B);
      bus.a_rdata   = (resp && (sel_q == PORT_A)) ? bus.mem_rdata : '0;
      bus.b_rdata   = (resp && (sel_q == PORT_B)) ? bus.mem_rdata : '0;
      bus.mem_addr  = issue ? addr_q : '0;
      bus.mem_wdata = issue ? wdata_q : '0;
      bus.mem_write = issue && we_q;
      bus.mem_read  = issue && !we_q;
      // held high outside reset so the memory's address-bypass never overwrites readData
      bus.mem_toreg = !rst;
      bus.busy      = state_q != IDLE;
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a behavioural 32-word memory.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   typedef struct {
      logic        port;
      logic        we;
      logic [19:0] addr;
      logic [19:0] data;
      int          cyc;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t gq[$];
   exp_t rq[$];
   logic [19:0] mem [MEM_WORDS];
   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   dmem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // memory stand-in: initialised to index, registered read, decodes addr[4:0]
   initial for (int i = 0; i < MEM_WORDS; i++) mem[i] = 20'(i);
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
      if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[4:0]];
   end
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   // monitor: per-cycle invariants plus scoreboard pops on gnt / rvalid
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         check("invariant", {bus.mem_read && bus.mem_write,
                             (bus.mem_read || bus.mem_write) != (bus.a_gnt || bus.b_gnt),
                             !bus.busy && (bus.a_gnt || bus.b_gnt || bus.a_rvalid || bus.b_rvalid),
                             !bus.mem_toreg, bus.a_gnt && bus.b_gnt, bus.a_rvalid && bus.b_rvalid,
                             (!bus.a_rvalid && bus.a_rdata != 0) || (!bus.b_rvalid && bus.b_rdata != 0)}, 0);
         if (bus.a_gnt || bus.b_gnt) begin
            if (gq.size() == 0) check("unexpected_gnt", {bus.b_gnt, bus.a_gnt}, 0);
            else begin
               e = gq.pop_front();
               check("gnt_cmd", {bus.b_gnt, bus.a_gnt, bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata},
                     {e.port, !e.port, e.we, !e.we, e.addr, e.data});
               check("gnt_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (bus.a_rvalid || bus.b_rvalid) begin
            if (rq.size() == 0) check("unexpected_rvalid", {bus.b_rvalid, bus.a_rvalid}, 0);
            else begin
               e = rq.pop_front();
               check("rdata", {bus.b_rvalid, bus.a_rvalid, bus.a_rdata, bus.b_rdata},
                     {e.port, !e.port, e.port ? 20'h0 : e.data, e.port ? e.data : 20'h0});
               check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end
   task automatic drive(input logic port, input logic req, input logic we, input logic [19:0] addr, input logic [19:0] wdata);
      if (port) begin
         bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
      end else begin
         bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
      end
   endtask
   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", bus.busy, 0);
   endtask
   task automatic xfer(input logic port, input logic we, input logic [19:0] addr, input logic [19:0] wdata, input logic [19:0] rexp);
      int n = 0;
      wait_idle();
      gq.push_back('{port, we, addr, wdata, cyc + 1});
      if (!we) rq.push_back('{port, 1'b0, addr, rexp, cyc + 2});
      drive(port, 1'b1, we, addr, wdata);
      do begin
         @(negedge clk);
         n++;
      end while (!(port ? bus.b_gnt : bus.a_gnt) && n < 10);
      check("gnt_seen", port ? bus.b_gnt : bus.a_gnt, 1);
      drive(port, 1'b0, 1'b0, 20'h0, 20'h0);
      if (!we) @(negedge clk);
   endtask
   initial begin
      int   n, g;
      logic p;
      drive(1'b0, 1'b0, 1'b0, 20'h0, 20'h0);
      drive(1'b1, 1'b0, 1'b0, 20'h0, 20'h0);
      repeat (2) @(negedge clk);
      check("reset_outputs", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_write, bus.mem_read,
                              bus.mem_toreg, bus.busy, bus.a_rdata | bus.b_rdata | bus.mem_addr | bus.mem_wdata}, 0);
      #2 rst = 1'b0;
      #1 check("toreg_release", bus.mem_toreg, 1);
      xfer(1'b1, 1'b0, 20'h7, 20'h0, 20'h7);
      xfer(1'b0, 1'b1, 20'h5, 20'h000AB, 20'h0);
      xfer(1'b0, 1'b0, 20'h5, 20'h0, 20'h000AB);
      xfer(1'b0, 1'b0, 20'h25, 20'h0, 20'h000AB);
      // write aborted by reset during its ISSUE cycle
      wait_idle();
      drive(1'b0, 1'b1, 1'b1, 20'h3, 20'hFFFFF);
      @(posedge clk);
      #2 check("issue_write", {bus.a_gnt, bus.mem_write}, 2'b11);
      #1 rst = 1'b1;
      #1 check("rst_outputs", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_write, bus.mem_read,
                               bus.mem_toreg, bus.busy, bus.a_rdata | bus.b_rdata | bus.mem_addr | bus.mem_wdata}, 0);
      drive(1'b0, 1'b0, 1'b0, 20'h0, 20'h0);
      @(negedge clk);
      #2 rst = 1'b0;
      // both ports read continuously for 8 grants
      wait_idle();
      for (int i = 0; i < 8; i++) begin
         p = RR & i[0];
         gq.push_back('{p, 1'b0, p ? 20'h2 : 20'h1, 20'h0, cyc + 1 + 3 * i});
         rq.push_back('{p, 1'b0, p ? 20'h2 : 20'h1, p ? 20'h2 : 20'h1, cyc + 2 + 3 * i});
      end
      drive(1'b0, 1'b1, 1'b0, 20'h1, 20'h0);
      drive(1'b1, 1'b1, 1'b0, 20'h2, 20'h0);
      n = 0;
      g = 0;
      while (g < 8 && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.a_gnt || bus.b_gnt) g++;
      end
      check("contention_grants", 64'(g), 8);
      drive(1'b0, 1'b0, 1'b0, 20'h0, 20'h0);
      drive(1'b1, 1'b0, 1'b0, 20'h0, 20'h0);
      xfer(1'b0, 1'b0, 20'h3, 20'h0, 20'h3);
      repeat (3) @(negedge clk);
      check("queues_empty", 64'(gq.size() + rq.size()), 0);
      check("idle_at_end", bus.busy, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish by %0t", $time);
      $fatal(1);
   end
endmodule
